pipe_mux_tree: RTL and testbench

- Parametrised, pipelined NUM_IN:1 multiplexer of WIDTH-bit words, built as a radix-4 tree with one register stage per tree level.
- Successor to the single-bit combinational 4:1/16:1 muxes. Intended for wide datapath selection in the ARM processor (register-file read ports, forwarding/result select) where a combinational 32/64-input mux breaks timing.
- Adds a valid/ready handshake with backpressure, a select echo, and out-of-range error reporting.

---
 rtl/pipe_mux_tree.sv | 148 ++++++++++++++
 tb/tb_pipe_mux_tree.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_tree.sv
// ----------------------------------------------------------------------------
// pipe_mux_tree
//   Pipelined NUM_IN:1 word multiplexer built as a radix-4 tree. Each tree
//   level is one register stage, so a request takes LEVELS cycles from
//   acceptance to out_valid. A valid/ready handshake with backpressure runs
//   through the stages. The select that produced each result is echoed back,
//   and out-of-range selects are flagged and return zero.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted this cycle
//   in_sel     channel index (SEL_W bits)
//   in_data    flattened inputs, channel k at [k*WIDTH +: WIDTH]
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   out_data   selected word (0 when out_err)
//   out_sel    select value that produced out_data
//   out_err    select was >= NUM_IN
// ----------------------------------------------------------------------------
module pipe_mux_tree #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 16,
    localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int LEVELS = (NUM_IN > 4) ? ($clog2(NUM_IN) + 1) / 2 : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err
);

    localparam int SELP_W = 2 * LEVELS;

    logic [LEVELS-1:0] w_vld;
    logic [LEVELS-1:0] w_adv;

    // Two select bits consumed by tree level lvl, from the zero-padded select.
    function automatic logic [1:0] sel_digit(input logic [SEL_W-1:0] sel, input int lvl);
        logic [SELP_W-1:0] sel_pad;
        sel_pad = SELP_W'(sel);
        return 2'(sel_pad >> (2 * lvl));
    endfunction

    function automatic logic is_err(input logic [SEL_W-1:0] sel);
        return (32'(sel) >= 32'(NUM_IN));
    endfunction

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
        localparam int CNT = 4 ** (LEVELS - 1 - gi);

        logic             r_vld;
        logic [SEL_W-1:0] r_sel;
        logic             r_err;
        logic [WIDTH-1:0] r_word [CNT];

        logic             w_up_vld;
        logic [SEL_W-1:0] w_up_sel;
        logic             w_up_err;
        logic [WIDTH-1:0] w_src [4*CNT];
        logic [WIDTH-1:0] w_nxt [CNT];
        logic [1:0]       w_dig;

        // Stage boundary: level 0 reads the ports, later levels read the
        // previous level's registers.
        if (gi == 0) begin : g_src
            assign w_up_vld = in_valid;
            assign w_up_sel = in_sel;
            assign w_up_err = is_err(in_sel);
            // Channels beyond NUM_IN read as zero, which also makes an
            // out-of-range select return zero data.
            for (genvar k = 0; k < 4*CNT; k++) begin : g_ch
                if (k < NUM_IN) begin : g_real
                    assign w_src[k] = in_data[k*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign w_src[k] = '0;
                end
            end
        end else begin : g_src
            assign w_up_vld = g_lvl[gi-1].r_vld;
            assign w_up_sel = g_lvl[gi-1].r_sel;
            assign w_up_err = g_lvl[gi-1].r_err;
            for (genvar k = 0; k < 4*CNT; k++) begin : g_ch
                assign w_src[k] = g_lvl[gi-1].r_word[k];
            end
        end

        assign w_dig = sel_digit(w_up_sel, gi);

        for (genvar j = 0; j < CNT; j++) begin : g_mux
            assign w_nxt[j] = (w_dig == 2'd0) ? w_src[4*j]     :
                              (w_dig == 2'd1) ? w_src[4*j + 1] :
                              (w_dig == 2'd2) ? w_src[4*j + 2] :
                                                w_src[4*j + 3];
        end

        // A level may load when any level from here to the output is empty,
        // or when the consumer takes the result this cycle.
        assign w_vld[gi] = r_vld;
        assign w_adv[gi] = out_ready | ~(&w_vld[LEVELS-1:gi]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld <= 1'b0;
                r_sel <= '0;
                r_err <= 1'b0;
            end else if (w_adv[gi]) begin
                r_vld <= w_up_vld;
                if (w_up_vld) begin
                    r_sel <= w_up_sel;
                    r_err <= w_up_err;
                end
            end
        end

        // Only the output level needs its data cleared by reset.
        if (gi == LEVELS - 1) begin : g_data
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_word <= '{default: '0};
                end else if (w_adv[gi] && w_up_vld) begin
                    r_word <= w_nxt;
                end
            end
        end else begin : g_data
            always_ff @(posedge clk) begin
                if (w_adv[gi] && w_up_vld) begin
                    r_word <= w_nxt;
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_vld[LEVELS-1];
    assign out_data  = g_lvl[LEVELS-1].r_word[0];
    assign out_sel   = g_lvl[LEVELS-1].r_sel;
    assign out_err   = g_lvl[LEVELS-1].r_err;

endmodule

// File: tb/tb_pipe_mux_tree.sv
// ----------------------------------------------------------------------------
// tb_pipe_mux_tree
//   Directed bench for pipe_mux_tree. Four instances cover NUM_IN = 16, 10,
//   64 and 1. Each scenario task drives one instance and checks its outputs
//   against hand-computed values.
// ----------------------------------------------------------------------------
module tb_pipe_mux_tree;

    logic clk;
    logic reset_n;

    int n_tests = 0;
    int n_fail  = 0;

    // NUM_IN = 16 instance
    logic         in_valid16, in_ready16, out_valid16, out_ready16, out_err16;
    logic [3:0]   in_sel16, out_sel16;
    logic [511:0] in_data16;
    logic [31:0]  out_data16;
    logic [31:0]  ch16 [16];

    // NUM_IN = 10 instance
    logic         in_valid10, in_ready10, out_valid10, out_ready10, out_err10;
    logic [3:0]   in_sel10, out_sel10;
    logic [319:0] in_data10;
    logic [31:0]  out_data10;
    logic [31:0]  ch10 [10];

    // NUM_IN = 64 instance
    logic          in_valid64, in_ready64, out_valid64, out_ready64, out_err64;
    logic [5:0]    in_sel64, out_sel64;
    logic [2047:0] in_data64;
    logic [31:0]   out_data64;
    logic [31:0]   ch64 [64];

    // NUM_IN = 1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
    logic [0:0]  in_sel1, out_sel1;
    logic [31:0] in_data1;
    logic [31:0] out_data1;

    for (genvar k = 0; k < 16; k++) begin : g_map16
        assign in_data16[k*32 +: 32] = ch16[k];
    end
    for (genvar k = 0; k < 10; k++) begin : g_map10
        assign in_data10[k*32 +: 32] = ch10[k];
    end
    for (genvar k = 0; k < 64; k++) begin : g_map64
        assign in_data64[k*32 +: 32] = ch64[k];
    end

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(16)) u16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_sel(in_sel16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_sel(out_sel16), .out_err(out_err16)
    );

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(10)) u10 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid10), .in_ready(in_ready10), .in_sel(in_sel10), .in_data(in_data10),
        .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10),
        .out_sel(out_sel10), .out_err(out_err10)
    );

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(64)) u64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_sel(in_sel64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
        .out_sel(out_sel64), .out_err(out_err64)
    );

    pipe_mux_tree #(.WIDTH(32), .NUM_IN(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_sel(in_sel1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_sel(out_sel1), .out_err(out_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        n_tests++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid16); end
        n_tests++; if (out_data16 !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h want=0", out_data16); end
        n_tests++; if (out_sel16 !== 4'h0) begin n_fail++; $display("FAIL rst_out_sel got=%h want=0", out_sel16); end
        n_tests++; if (out_err16 !== 1'b0) begin n_fail++; $display("FAIL rst_out_err got=%b want=0", out_err16); end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        n_tests++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready16); end

        // Put two requests in flight in u16 and one error request in u10.
        out_ready16 = 1'b0;
        out_ready10 = 1'b0;
        in_valid16 = 1'b1; in_sel16 = 4'd1;
        in_valid10 = 1'b1; in_sel10 = 4'd12;
        tick();
        in_sel16 = 4'd2;
        in_valid10 = 1'b0;
        tick();
        in_valid16 = 1'b0;
        #1;
        n_tests++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL inflight_valid got=%b want=1", out_valid16); end
        n_tests++; if (out_sel16 !== 4'd1) begin n_fail++; $display("FAIL inflight_sel got=%0d want=1", out_sel16); end
        n_tests++; if (out_err10 !== 1'b1) begin n_fail++; $display("FAIL inflight_err10 got=%b want=1", out_err10); end

        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%b want=0", out_valid16); end
        n_tests++; if (out_data16 !== 32'h0) begin n_fail++; $display("FAIL async_rst_data got=%h want=0", out_data16); end
        n_tests++; if (out_sel16 !== 4'h0) begin n_fail++; $display("FAIL async_rst_sel got=%h want=0", out_sel16); end
        n_tests++; if (out_err10 !== 1'b0) begin n_fail++; $display("FAIL async_rst_err10 got=%b want=0", out_err10); end
        n_tests++; if (out_valid10 !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid10 got=%b want=0", out_valid10); end
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        out_ready16 = 1'b1;
        out_ready10 = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_tests++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL stale_valid16 cyc=%0d got=%b want=0", c, out_valid16); end
            n_tests++; if (out_valid10 !== 1'b0) begin n_fail++; $display("FAIL stale_valid10 cyc=%0d got=%b want=0", c, out_valid10); end
            tick();
        end
        n_tests++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready16); end
    endtask

    // sel 0..15 back to back, out_ready held high: results appear in cycles 2..17.
    task automatic test_back_to_back();
        out_ready16 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid16 = (c < 16);
            in_sel16   = 4'(c);
            #1;
            n_tests++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", c, in_ready16); end
            tick();
            if (c >= 1 && c <= 16) begin
                n_tests++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b want=1", c + 1, out_valid16); end
                n_tests++; if (out_data16 !== 32'(32'hA000_0000 + c - 1)) begin n_fail++; $display("FAIL stream_data cyc=%0d got=%h want=%h", c + 1, out_data16, 32'(32'hA000_0000 + c - 1)); end
                n_tests++; if (out_sel16 !== 4'(c - 1)) begin n_fail++; $display("FAIL stream_sel cyc=%0d got=%0d want=%0d", c + 1, out_sel16, c - 1); end
                n_tests++; if (out_err16 !== 1'b0) begin n_fail++; $display("FAIL stream_err cyc=%0d got=%b want=0", c + 1, out_err16); end
            end else begin
                n_tests++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL stream_idle cyc=%0d got=%b want=0", c + 1, out_valid16); end
            end
        end
        in_valid16 = 1'b0;
    endtask

    // Push 3,7,11,15 with out_ready low for 6 cycles, then release.
    task automatic test_backpressure();
        int  np;
        int  no;
        logic acc;
        logic emit;
        np = 0;
        no = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready16 = (c >= 6);
            in_valid16  = (np < 4);
            in_sel16    = 4'(4 * np + 3);
            #1;
            if (c >= 2 && c < 6) begin
                n_tests++; if (in_ready16 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready16); end
                n_tests++; if (np !== 2) begin n_fail++; $display("FAIL bp_accepts cyc=%0d got=%0d want=2", c, np); end
                n_tests++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", c, out_valid16); end
                n_tests++; if (out_data16 !== 32'hA000_0003) begin n_fail++; $display("FAIL bp_hold_data cyc=%0d got=%h want=a0000003", c, out_data16); end
                n_tests++; if (out_sel16 !== 4'd3) begin n_fail++; $display("FAIL bp_hold_sel cyc=%0d got=%0d want=3", c, out_sel16); end
            end
            acc  = in_valid16 & in_ready16;
            emit = out_valid16 & out_ready16;
            if (emit) begin
                n_tests++; if (no >= 4) begin n_fail++; $display("FAIL bp_extra_out cyc=%0d got=%0d results want=4", c, no + 1); end
                n_tests++; if (out_sel16 !== 4'(4 * no + 3)) begin n_fail++; $display("FAIL bp_order_sel cyc=%0d got=%0d want=%0d", c, out_sel16, 4 * no + 3); end
                n_tests++; if (out_data16 !== 32'(32'hA000_0000 + 4 * no + 3)) begin n_fail++; $display("FAIL bp_order_data cyc=%0d got=%h want=%h", c, out_data16, 32'(32'hA000_0000 + 4 * no + 3)); end
                no++;
            end
            tick();
            if (acc) np++;
        end
        in_valid16 = 1'b0;
        n_tests++; if (np !== 4) begin n_fail++; $display("FAIL bp_total_in got=%0d want=4", np); end
        n_tests++; if (no !== 4) begin n_fail++; $display("FAIL bp_total_out got=%0d want=4", no); end
    endtask

    task automatic test_out_of_range();
        out_ready10 = 1'b1;
        in_valid10  = 1'b1;
        in_sel10    = 4'd12;
        #1;
        n_tests++; if (in_ready10 !== 1'b1) begin n_fail++; $display("FAIL oor_in_ready0 got=%b want=1", in_ready10); end
        tick();
        in_sel10 = 4'd9;
        #1;
        n_tests++; if (in_ready10 !== 1'b1) begin n_fail++; $display("FAIL oor_in_ready1 got=%b want=1", in_ready10); end
        tick();
        in_valid10 = 1'b0;
        n_tests++; if (out_valid10 !== 1'b1) begin n_fail++; $display("FAIL oor_valid got=%b want=1", out_valid10); end
        n_tests++; if (out_err10 !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b want=1", out_err10); end
        n_tests++; if (out_data10 !== 32'h0) begin n_fail++; $display("FAIL oor_data got=%h want=0", out_data10); end
        n_tests++; if (out_sel10 !== 4'd12) begin n_fail++; $display("FAIL oor_sel got=%0d want=12", out_sel10); end
        tick();
        n_tests++; if (out_valid10 !== 1'b1) begin n_fail++; $display("FAIL ch9_valid got=%b want=1", out_valid10); end
        n_tests++; if (out_err10 !== 1'b0) begin n_fail++; $display("FAIL ch9_err got=%b want=0", out_err10); end
        n_tests++; if (out_data10 !== 32'hB000_0009) begin n_fail++; $display("FAIL ch9_data got=%h want=b0000009", out_data10); end
        n_tests++; if (out_sel10 !== 4'd9) begin n_fail++; $display("FAIL ch9_sel got=%0d want=9", out_sel10); end
        tick();
        n_tests++; if (out_valid10 !== 1'b0) begin n_fail++; $display("FAIL oor_drain got=%b want=0", out_valid10); end
    endtask

    task automatic test_depth();
        // Three-level tree: result three cycles after the request cycle.
        out_ready64 = 1'b1;
        in_valid64  = 1'b1;
        in_sel64    = 6'd63;
        tick();
        in_sel64 = 6'd21;
        n_tests++; if (out_valid64 !== 1'b0) begin n_fail++; $display("FAIL d64_lat1 got=%b want=0", out_valid64); end
        tick();
        in_valid64 = 1'b0;
        n_tests++; if (out_valid64 !== 1'b0) begin n_fail++; $display("FAIL d64_lat2 got=%b want=0", out_valid64); end
        tick();
        n_tests++; if (out_valid64 !== 1'b1) begin n_fail++; $display("FAIL d64_lat3 got=%b want=1", out_valid64); end
        n_tests++; if (out_data64 !== 32'hC000_003F) begin n_fail++; $display("FAIL d64_data63 got=%h want=c000003f", out_data64); end
        n_tests++; if (out_sel64 !== 6'd63) begin n_fail++; $display("FAIL d64_sel63 got=%0d want=63", out_sel64); end
        tick();
        n_tests++; if (out_data64 !== 32'hC000_0015) begin n_fail++; $display("FAIL d64_data21 got=%h want=c0000015", out_data64); end
        n_tests++; if (out_sel64 !== 6'd21) begin n_fail++; $display("FAIL d64_sel21 got=%0d want=21", out_sel64); end

        // Single-input instance: one level, sel=1 is out of range.
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_sel1    = 1'b0;
        tick();
        in_sel1 = 1'b1;
        n_tests++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL d1_valid got=%b want=1", out_valid1); end
        n_tests++; if (out_data1 !== 32'h5A5A_0001) begin n_fail++; $display("FAIL d1_data got=%h want=5a5a0001", out_data1); end
        n_tests++; if (out_err1 !== 1'b0) begin n_fail++; $display("FAIL d1_err0 got=%b want=0", out_err1); end
        tick();
        in_valid1 = 1'b0;
        n_tests++; if (out_err1 !== 1'b1) begin n_fail++; $display("FAIL d1_err1 got=%b want=1", out_err1); end
        n_tests++; if (out_data1 !== 32'h0) begin n_fail++; $display("FAIL d1_err_data got=%h want=0", out_data1); end
        n_tests++; if (out_sel1 !== 1'b1) begin n_fail++; $display("FAIL d1_sel got=%b want=1", out_sel1); end
        tick();
        n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL d1_drain got=%b want=0", out_valid1); end
    endtask

    task automatic test_capture();
        out_ready16 = 1'b1;
        ch16[5]     = 32'h0000_1234;
        in_valid16  = 1'b1;
        in_sel16    = 4'd5;
        tick();
        ch16[5]    = 32'h0000_FFFF;
        in_valid16 = 1'b0;
        in_sel16   = 4'd0;
        tick();
        n_tests++; if (out_valid16 !== 1'b1) begin n_fail++; $display("FAIL cap_valid got=%b want=1", out_valid16); end
        n_tests++; if (out_data16 !== 32'h0000_1234) begin n_fail++; $display("FAIL cap_data got=%h want=00001234", out_data16); end
        n_tests++; if (out_sel16 !== 4'd5) begin n_fail++; $display("FAIL cap_sel got=%0d want=5", out_sel16); end
        ch16[5] = 32'hA000_0005;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid16 = 1'b0; in_sel16 = '0; out_ready16 = 1'b0;
        in_valid10 = 1'b0; in_sel10 = '0; out_ready10 = 1'b0;
        in_valid64 = 1'b0; in_sel64 = '0; out_ready64 = 1'b0;
        in_valid1  = 1'b0; in_sel1  = '0; out_ready1  = 1'b0;
        for (int k = 0; k < 16; k++) ch16[k] = 32'(32'hA000_0000 + k);
        for (int k = 0; k < 10; k++) ch10[k] = 32'(32'hB000_0000 + k);
        for (int k = 0; k < 64; k++) ch64[k] = 32'(32'hC000_0000 + k);
        in_data1 = 32'h5A5A_0001;

        test_reset();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_depth();
        test_capture();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
